// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
// Contents:
//   ST_* state encodings plus the rx_state_e enum built from them,
//   DATA_BITS (frame payload width),
//   calc_div() for the sysclk-to-sample-tick divide ratio.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP,
        BREAK = ST_BREAK
    } rx_state_e;

    // Integer division. It is clamped to 1 so that a too-fast baud setting
    // produces a tick on every cycle instead of a zero-length divider.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick generator. The transmit side reuses it.
// Ports:
//   sysclk - clock, rising edge
//   reset  - synchronous, active-high; clears the divider to 0
//   tick   - one-cycle pulse every DIV cycles
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic sysclk,
    input  logic reset,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 UART receive front end. Data is sent LSB first.
// The raw line goes through a 2-flop synchronizer. Each bit is decided by a
// 3-sample majority vote around the middle of the bit. A start bit that is
// not confirmed by the vote is dropped as a glitch. A bad stop bit puts the
// FSM in BREAK, where it stays until the line returns high.
// Ports:
//   sysclk      - clock, rising edge
//   reset       - synchronous, active-high
//   UART_RX     - asynchronous serial input, idles high
//   recv_enable - 0 forces IDLE and discards any partial frame
//   rx_data     - last correctly framed byte; held until the next rx_valid
//   rx_valid    - one-cycle pulse, rx_data is new in the same cycle
//   frame_err   - one-cycle pulse, stop bit sampled as 0
//   busy        - a frame is in progress (state != IDLE)
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    input  logic                 recv_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int            DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int            MID    = OVERSAMPLE / 2;
    localparam int            SW     = $clog2(OVERSAMPLE);
    localparam int            BW     = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_LO   = SW'(MID - 1);
    localparam logic [SW-1:0] S_MID  = SW'(MID);
    localparam logic [SW-1:0] S_HI   = SW'(MID + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic tick;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .sysclk (sysclk),
        .reset  (reset),
        .tick   (tick)
    );

    rx_state_e              state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [SW-1:0]          s_q, s_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [1:0]             vote_q, vote_d;     // samples at MID-1 and MID
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic          line;
    logic          vote;
    logic          active;
    logic [SW-1:0] idx;

    always_comb begin
        sync_d = {sync_q[0], UART_RX};
        line   = sync_q[1];
        // s_q holds the index of the most recent tick, so idx is the index of
        // the current tick. The wrap is explicit because OVERSAMPLE need not
        // be a power of two.
        idx    = (s_q == S_LAST) ? '0 : s_q + 1'b1;
        // The sample at MID+1 is the live line value.
        vote   = (vote_q[0] & vote_q[1]) | (vote_q[0] & line) | (vote_q[1] & line);
        active = (state_q == START) || (state_q == DATA) || (state_q == STOP);

        state_d     = state_q;
        s_d         = s_q;
        bit_d       = bit_q;
        vote_d      = vote_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (tick && active) begin
            s_d = idx;
            if (idx == S_LO)  vote_d[0] = line;
            if (idx == S_MID) vote_d[1] = line;
        end

        if (!recv_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // The tick that detects the low line is index 0 of the start bit.
                    if (tick && !line) begin
                        state_d = START;
                        s_d     = '0;
                    end
                end
                START: begin
                    if (tick && idx == S_HI && vote) begin
                        state_d = IDLE;
                    end else if (tick && idx == S_LAST) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (tick && idx == S_HI) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (tick && idx == S_LAST) begin
                        if (bit_q == B_LAST) state_d = STOP;
                        else                 bit_d   = bit_q + 1'b1;
                    end
                end
                STOP: begin
                    // The decision is made mid stop bit so that a back-to-back
                    // start edge is still seen.
                    if (tick && idx == S_HI) begin
                        if (vote) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (line) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            s_q         <= '0;
            bit_q       <= '0;
            vote_q      <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            s_q         <= s_d;
            bit_q       <= bit_d;
            vote_q      <= vote_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
